// File: rtl/node_accumulator_if.sv
`default_nettype none
//==============================================================================
// Module      : node_accumulator_if
// Description : Command, x/w stream and result handshake bundle for
//               node_accumulator.
// Revision    : 1.0 - initial release
//==============================================================================
interface node_accumulator_if #(
    parameter int CNT_W = 10
);
    logic             start;
    logic [CNT_W-1:0] n_inputs;
    logic [21:0]      bias;
    logic             x_valid;
    logic [7:0]       x_data;
    logic [7:0]       w_data;
    logic             x_ready;
    logic [21:0]      y;
    logic             y_valid;
    logic             y_ready;
    logic             busy;

    modport master (
        output start, n_inputs, bias, x_valid, x_data, w_data, y_ready,
        input  x_ready, y, y_valid, busy
    );

    modport slave (
        input  start, n_inputs, bias, x_valid, x_data, w_data, y_ready,
        output x_ready, y, y_valid, busy
    );
endinterface
`default_nettype wire

// File: rtl/node_accumulator.sv
`default_nettype none
//==============================================================================
// Module      : node_accumulator
// Description : Neuron MAC - bias plus sum of unsigned x times signed w,
//               saturated to a 22-bit signed result with valid/ready output.
// Revision    : 1.0 - initial release
//==============================================================================
module node_accumulator #(
    parameter int CNT_W = 10
) (
    input  wire               clk,
    input  wire               rst,
    node_accumulator_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic signed [31:0] c_pos_lim = 32'sd2097151;
    localparam logic signed [31:0] c_neg_lim = -32'sd2097152;

    state_t             r_state;
    state_t             w_next;
    logic signed [31:0] r_acc;
    logic signed [31:0] w_acc_next;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_next;
    logic [21:0]        r_y;
    logic [21:0]        w_sat;
    logic signed [16:0] w_xs;
    logic signed [16:0] w_ws;
    logic signed [16:0] w_prod;

    // x is unsigned, so it is zero-extended before the signed multiply.
    assign w_xs   = {9'd0, bus.x_data};
    assign w_ws   = {{9{bus.w_data[7]}}, bus.w_data};
    assign w_prod = w_xs * w_ws;

    always_comb begin
        w_next       = r_state;
        w_acc_next   = r_acc;
        w_count_next = r_count;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_acc_next   = {{10{bus.bias[21]}}, bus.bias};
                    w_count_next = bus.n_inputs;
                    w_next       = (bus.n_inputs == '0) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (bus.x_valid) begin
                    w_acc_next   = r_acc + {{15{w_prod[16]}}, w_prod};
                    w_count_next = r_count - 1'b1;
                    if (r_count == CNT_W'(1)) begin
                        w_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (bus.y_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Saturate the value that is about to be committed, so y is ready on DONE entry.
    always_comb begin
        w_sat = w_acc_next[21:0];
        if (w_acc_next > c_pos_lim) begin
            w_sat = 22'h1FFFFF;
        end else if (w_acc_next < c_neg_lim) begin
            w_sat = 22'h200000;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_count <= '0;
            r_y     <= '0;
        end else begin
            r_state <= w_next;
            r_acc   <= w_acc_next;
            r_count <= w_count_next;
            if ((w_next == S_DONE) && (r_state != S_DONE)) begin
                r_y <= w_sat;
            end
        end
    end

    assign bus.x_ready = (r_state == S_ACCUM);
    assign bus.y_valid = (r_state == S_DONE);
    assign bus.busy    = (r_state != S_IDLE);
    assign bus.y       = r_y;
endmodule
`default_nettype wire

// File: tb/tb_node_accumulator.sv
`default_nettype none
//==============================================================================
// Module      : tb_node_accumulator
// Description : Table-driven self-checking bench for node_accumulator.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_node_accumulator;
    typedef struct packed {
        logic [9:0]         n;
        logic signed [21:0] bias;
        logic [3:0][7:0]    x;
        logic [3:0][7:0]    w;
        logic               gap;
        logic [3:0]         hold;
        logic [21:0]        exp_y;
    } vec_t;

    localparam int c_nvec = 7;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    vec_t vecs [c_nvec];

    node_accumulator_if #(.CNT_W(10)) bus ();

    node_accumulator #(.CNT_W(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.start    = 1'b0;
        bus.x_valid  = 1'b0;
        bus.y_ready  = 1'b0;
        bus.n_inputs = '0;
        bus.bias     = '0;
        bus.x_data   = '0;
        bus.w_data   = '0;
    endtask

    // Drives one evaluation from IDLE through the output handshake.
    task automatic run_vec(input vec_t v, input string name);
        logic [21:0] y_seen;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.n_inputs = v.n;
        bus.bias     = v.bias;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.n_inputs = 10'd5;
        bus.bias     = 22'h12345;
        for (int i = 0; i < int'(v.n); i++) begin
            if (v.gap) begin
                bus.x_valid = 1'b0;
                bus.x_data  = 8'hFF;
                bus.w_data  = 8'h7F;
                @(negedge clk);
            end
            chk({name, "_early_valid"}, {31'd0, bus.y_valid}, 32'd0);
            chk({name, "_x_ready"}, {31'd0, bus.x_ready}, 32'd1);
            bus.x_valid = 1'b1;
            bus.x_data  = v.x[i];
            bus.w_data  = v.w[i];
            @(negedge clk);
            bus.x_valid = 1'b0;
        end
        chk({name, "_y_valid"}, {31'd0, bus.y_valid}, 32'd1);
        chk({name, "_x_ready_done"}, {31'd0, bus.x_ready}, 32'd0);
        chk({name, "_y"}, {10'd0, bus.y}, {10'd0, v.exp_y});
        y_seen = bus.y;
        for (int k = 0; k < int'(v.hold); k++) begin
            @(negedge clk);
            chk({name, "_hold_busy"}, {31'd0, bus.busy}, 32'd1);
            chk({name, "_hold_y"}, {10'd0, bus.y}, {10'd0, y_seen});
            chk({name, "_hold_valid"}, {31'd0, bus.y_valid}, 32'd1);
        end
        bus.y_ready = 1'b1;
        @(negedge clk);
        bus.y_ready = 1'b0;
        chk({name, "_post_valid"}, {31'd0, bus.y_valid}, 32'd0);
        chk({name, "_post_busy"}, {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic sat_run(input logic [7:0] w, input logic [21:0] exp, input string name);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.n_inputs = 10'd784;
        bus.bias     = '0;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.x_valid  = 1'b1;
        bus.x_data   = 8'd255;
        bus.w_data   = w;
        for (int i = 0; i < 784; i++) @(negedge clk);
        bus.x_valid = 1'b0;
        chk({name, "_valid"}, {31'd0, bus.y_valid}, 32'd1);
        chk({name, "_y"}, {10'd0, bus.y}, {10'd0, exp});
        bus.y_ready = 1'b1;
        @(negedge clk);
        bus.y_ready = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        // 10*5 + 20*(-3) + 255*127 + 100
        vecs[0] = '{n: 10'd3, bias: 22'sd100, x: {8'd0, 8'd255, 8'd20, 8'd10},
                    w: {8'h00, 8'h7F, 8'hFD, 8'h05}, gap: 1'b0, hold: 4'd0, exp_y: 22'd32475};
        // 200*(-128) + 100*(-1) + 0*77 + 255*(-100) - 1000 = -52200
        vecs[1] = '{n: 10'd4, bias: -22'sd1000, x: {8'd255, 8'd0, 8'd100, 8'd200},
                    w: {8'h9C, 8'h4D, 8'hFF, 8'h80}, gap: 1'b1, hold: 4'd5, exp_y: 22'h3F3418};
        vecs[2] = '{n: 10'd0, bias: -22'sd7, x: '0, w: '0, gap: 1'b0, hold: 4'd0,
                    exp_y: 22'h3FFFF9};
        vecs[3] = '{n: 10'd1, bias: 22'sd2097151, x: {24'd0, 8'd1}, w: {24'd0, 8'h01},
                    gap: 1'b0, hold: 4'd1, exp_y: 22'h1FFFFF};
        vecs[4] = '{n: 10'd1, bias: -22'sd2097152, x: {24'd0, 8'd0}, w: {24'd0, 8'h05},
                    gap: 1'b0, hold: 4'd0, exp_y: 22'h200000};
        vecs[5] = '{n: 10'd2, bias: 22'sd2097151, x: {16'd0, 8'd0, 8'd1},
                    w: {16'd0, 8'h00, 8'hFF}, gap: 1'b0, hold: 4'd0, exp_y: 22'h1FFFFE};
        vecs[6] = '{n: 10'd1, bias: -22'sd2097152, x: {24'd0, 8'd1}, w: {24'd0, 8'hFF},
                    gap: 1'b1, hold: 4'd0, exp_y: 22'h200000};

        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_y_valid", {31'd0, bus.y_valid}, 32'd0);
        chk("rst_x_ready", {31'd0, bus.x_ready}, 32'd0);
        chk("rst_y", {10'd0, bus.y}, 32'd0);

        // First start is taken on the first rising edge after release.
        rst          = 1'b0;
        bus.start    = 1'b1;
        bus.n_inputs = 10'd2;
        bus.bias     = 22'sd0;
        @(negedge clk);
        bus.start = 1'b0;
        chk("first_start_busy", {31'd0, bus.busy}, 32'd1);
        bus.x_valid = 1'b1;
        bus.x_data  = 8'd3;
        bus.w_data  = 8'h04;
        @(negedge clk);
        @(negedge clk);
        bus.x_valid = 1'b0;
        chk("first_y", {10'd0, bus.y}, 32'd24);
        bus.y_ready = 1'b1;
        @(negedge clk);
        bus.y_ready = 1'b0;

        // Pairs offered while idle must not be absorbed.
        bus.x_valid = 1'b1;
        bus.x_data  = 8'd200;
        bus.w_data  = 8'h7F;
        @(negedge clk);
        @(negedge clk);
        bus.x_valid = 1'b0;
        chk("idle_x_ready", {31'd0, bus.x_ready}, 32'd0);

        for (int i = 0; i < c_nvec; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        sat_run(8'h7F, 22'h1FFFFF, "sat_pos");
        sat_run(8'h80, 22'h200000, "sat_neg");

        // Reset after 2 of 5 transfers abandons the evaluation.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.n_inputs = 10'd5;
        bus.bias     = 22'sd50;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.x_valid = 1'b1;
        bus.x_data  = 8'd9;
        bus.w_data  = 8'h09;
        @(negedge clk);
        @(negedge clk);
        bus.x_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("async_rst_x_ready", {31'd0, bus.x_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_valid", {31'd0, bus.y_valid}, 32'd0);
        end
        vecs[0] = '{n: 10'd1, bias: 22'sd0, x: {24'd0, 8'd2}, w: {24'd0, 8'h03},
                    gap: 1'b0, hold: 4'd0, exp_y: 22'd6};
        run_vec(vecs[0], "after_rst");

        // Reset while a result waits in DONE.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.n_inputs = 10'd0;
        bus.bias     = 22'sd77;
        @(negedge clk);
        bus.start = 1'b0;
        chk("done_pre_rst_valid", {31'd0, bus.y_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("done_rst_valid", {31'd0, bus.y_valid}, 32'd0);
        chk("done_rst_y", {10'd0, bus.y}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("done_rst_idle", {31'd0, bus.busy}, 32'd0);

        // Start pulses during ACCUM and in the final handshake cycle are ignored.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.n_inputs = 10'd2;
        bus.bias     = 22'sd1;
        @(negedge clk);
        bus.x_valid  = 1'b1;
        bus.x_data   = 8'd4;
        bus.w_data   = 8'h05;
        bus.n_inputs = 10'd7;
        bus.bias     = 22'sd999;
        @(negedge clk);
        bus.x_data = 8'd6;
        bus.w_data = 8'hFE;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.x_valid = 1'b0;
        chk("ign_start_y", {10'd0, bus.y}, 32'd9);
        bus.start   = 1'b1;
        bus.y_ready = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.y_ready = 1'b0;
        chk("ign_start_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        chk("ign_start_still_idle", {31'd0, bus.busy}, 32'd0);
        chk("ign_start_no_valid", {31'd0, bus.y_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
